cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 25 ++
 rtl/cdb_arbiter.sv | 74 +++++++
 tb/tb_cdb_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Common data bus request/broadcast bundle between the execution units and the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [3:0]          req_valid;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic                flush;
  logic [3:0]          req_grant;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [15:0]         cdb_count;

  modport slave (
    input  req_valid, req_tag, req_data, flush,
    output req_grant, cdb_valid, cdb_tag, cdb_data, cdb_count
  );

  modport master (
    output req_valid, req_tag, req_data, flush,
    input  req_grant, cdb_valid, cdb_tag, cdb_data, cdb_count
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Four-way round-robin arbiter for the common data bus: combinational one-hot grant,
// registered broadcast of the winner's tag/result, saturating broadcast counter.
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  logic [1:0]        ptr;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic              grant_any;
  logic [3:0]        grant;
  logic [TAG_W-1:0]  tag_sel;
  logic [DATA_W-1:0] data_sel;

  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] data_p1;
  logic [15:0]       count_p1;

  // Stage 0: search from ptr upward (mod 4); reset and flush both mask the grant.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant_any = found && rst_n && !bus.flush;
    grant     = 4'b0000;
    if (grant_any) grant[win] = 1'b1;
    tag_sel  = bus.req_tag[win*TAG_W +: TAG_W];
    data_sel = bus.req_data[win*DATA_W +: DATA_W];
  end

  // Stage 1: broadcast register; tag/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= 2'd0;
      vld_p1   <= 1'b0;
      tag_p1   <= '0;
      data_p1  <= '0;
      count_p1 <= 16'd0;
    end else begin
      vld_p1 <= grant_any;
      if (grant_any) begin
        ptr      <= win + 2'd1;
        tag_p1   <= tag_sel;
        data_p1  <= data_sel;
        count_p1 <= sat_inc(count_p1);
      end
    end
  end

  assign bus.req_grant = grant;
  assign bus.cdb_valid = vld_p1;
  assign bus.cdb_tag   = tag_p1;
  assign bus.cdb_data  = data_p1;
  assign bus.cdb_count = count_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed steps push expected grant/bus values,
// a negedge monitor pops and compares them against the DUT.
module tb_cdb_arbiter;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  typedef struct {
    int                cyc;
    logic [3:0]        grant;
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [15:0]       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t gq[$];
  exp_t bq[$];

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      checks++;
      if (bus.req_grant !== e.grant) begin
        fails++;
        $display("FAIL grant cyc %0d: got %b want %b", cyc, bus.req_grant, e.grant);
      end
    end
    if (bq.size() > 0 && bq[0].cyc + 1 == cyc) begin
      e = bq.pop_front();
      checks++;
      if (bus.cdb_valid !== e.v || bus.cdb_tag !== e.tag ||
          bus.cdb_data !== e.data || bus.cdb_count !== e.cnt) begin
        fails++;
        $display("FAIL bus cyc %0d: got v=%b tag=%0d data=%h cnt=%h want v=%b tag=%0d data=%h cnt=%h",
                 cyc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_count,
                 e.v, e.tag, e.data, e.cnt);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] v, input logic f,
                      input logic [3:0] g, input logic cv, input logic [TAG_W-1:0] t,
                      input logic [DATA_W-1:0] d, input logic [15:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.req_valid = v;
    bus.flush     = f;
    e.cyc = cyc; e.grant = g; e.v = cv; e.tag = t; e.data = d; e.cnt = c;
    gq.push_back(e);
    bq.push_back(e);
  endtask

  task automatic bulk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.req_valid = 4'b1111;
      bus.flush     = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.flush     = 1'b0;
    // unit tags 1,3,5,9 and results 100,200,7,400 (hex)
    bus.req_tag   = {4'd9, 4'd5, 4'd3, 4'd1};
    bus.req_data  = {32'h400, 32'h7, 32'h200, 32'h100};

    // reset with requests present: no grant, bus cleared
    step(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 16'd0);
    step(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 16'd0);

    // single request on unit 2
    step(1, 4'b0100, 0, 4'b0100, 1, 5, 32'h7, 16'd1);
    step(1, 4'b0000, 0, 4'b0000, 0, 5, 32'h7, 16'd1);

    // all four continuously valid after reset
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 16'd0);
    step(1, 4'b1111, 0, 4'b0001, 1, 1, 32'h100, 16'd1);
    step(1, 4'b1111, 0, 4'b0010, 1, 3, 32'h200, 16'd2);
    step(1, 4'b1111, 0, 4'b0100, 1, 5, 32'h7,   16'd3);
    step(1, 4'b1111, 0, 4'b1000, 1, 9, 32'h400, 16'd4);
    step(1, 4'b1111, 0, 4'b0001, 1, 1, 32'h100, 16'd5);

    // ptr=1 -> grant unit1 (ptr=2), then wrap-around search picks unit0
    step(1, 4'b0010, 0, 4'b0010, 1, 3, 32'h200, 16'd6);
    step(1, 4'b0011, 0, 4'b0001, 1, 1, 32'h100, 16'd7);
    step(1, 4'b0010, 0, 4'b0010, 1, 3, 32'h200, 16'd8);

    // flush suppresses, bus holds tag/data, count unchanged
    step(1, 4'b1000, 1, 4'b0000, 0, 3, 32'h200, 16'd8);
    step(1, 4'b1000, 0, 4'b1000, 1, 9, 32'h400, 16'd9);
    // held valid is a new request at post-grant priority (ptr=0)
    step(1, 4'b1000, 0, 4'b1000, 1, 9, 32'h400, 16'd10);
    step(1, 4'b1001, 0, 4'b0001, 1, 1, 32'h100, 16'd11);

    // drive ptr to 3, then reset mid-operation; release grants from ptr=0
    step(1, 4'b0100, 0, 4'b0100, 1, 5, 32'h7, 16'd12);
    step(0, 4'b0110, 0, 4'b0000, 0, 0, 0, 16'd0);
    step(1, 4'b0110, 0, 4'b0010, 1, 3, 32'h200, 16'd1);

    // saturation: reset, 65533 grants leave count=FFFD, ptr=1
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 16'd0);
    bulk(65533);
    step(1, 4'b1111, 0, 4'b0010, 1, 3, 32'h200, 16'hFFFE);
    step(1, 4'b1111, 0, 4'b0100, 1, 5, 32'h7,   16'hFFFF);
    step(1, 4'b1111, 0, 4'b1000, 1, 9, 32'h400, 16'hFFFF);
    step(1, 4'b1111, 0, 4'b0001, 1, 1, 32'h100, 16'hFFFF);
    step(1, 4'b0000, 1, 4'b0000, 0, 1, 32'h100, 16'hFFFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (gq.size() != 0 || bq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", gq.size(), bq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
